// File: rtl/display_scan_driver_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
package display_pkg;

  typedef enum logic {
    GAP  = 1'b0,
    SHOW = 1'b1
  } scan_state_e;

  localparam int NIBBLE_W = 4;
  localparam logic [NIBBLE_W-1:0] SEG_DARK = 4'h0;

  function automatic int idx_width(input int digits);
    return (digits <= 2) ? 1 : $clog2(digits);
  endfunction

endpackage

// File: rtl/display_scan_driver_if.sv
// Value/control inputs and segment/digit outputs of the scan driver.
interface display_scan_driver_if
  import display_pkg::*;
#(
  parameter int DIGITS = 4
);

  logic [NIBBLE_W*DIGITS-1:0] value;
  logic                       load;
  logic                       blank_lz;
  logic [NIBBLE_W-1:0]        seg_val;
  logic [DIGITS-1:0]          digit_sel;
  logic                       frame;

  modport master (
    output value, load, blank_lz,
    input  seg_val, digit_sel, frame
  );

  modport slave (
    input  value, load, blank_lz,
    output seg_val, digit_sel, frame
  );

endinterface

// File: rtl/display_scan_timer.sv
// Digit scan sequencer: alternates dark gaps and lit slots, stepping the digit index.
//   state | meaning
//   GAP   | all digits dark; idx advances (wrapping) on the last gap cycle
//   SHOW  | digit idx lit for SCAN_DIV cycles
module display_scan_timer
  import display_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int GAP_CYC  = 500,
  parameter int IDX_W    = idx_width(DIGITS)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             show_nxt,
  output logic [IDX_W-1:0] idx_nxt,
  output logic             wrap
);

  localparam int CNT_MAX = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GAP;
      cnt_q   <= '0;
      idx_q   <= LAST_IDX;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    unique case (state_q)
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = SHOW;
          // explicit wrap so non-power-of-two digit counts never overflow into unused codes
          idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
      end
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = GAP;
      end
    endcase
  end

  always_comb begin
    show_nxt = (state_d == SHOW);
    idx_nxt  = idx_d;
    wrap     = (state_q == GAP) && (state_d == SHOW) && (idx_d == '0);
  end

endmodule

// File: rtl/display_scan_driver.sv
// Multiplexed 7-segment scan driver: frame-synchronous value update, leading-zero blanking.
module display_scan_driver
  import display_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int GAP_CYC  = 500
) (
  input logic                  clk,
  input logic                  rst,
  display_scan_driver_if.slave bus
);

  localparam int IDX_W = idx_width(DIGITS);
  localparam int VAL_W = NIBBLE_W * DIGITS;

  logic             show_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             wrap;

  logic [VAL_W-1:0]    active_q, active_d;
  logic [VAL_W-1:0]    pending_q, pending_d;
  logic                pend_vld_q, pend_vld_d;
  logic [DIGITS-1:0]   lz_vec;
  logic                lz_run;
  logic [NIBBLE_W-1:0] seg_d, seg_q;
  logic [DIGITS-1:0]   sel_d, sel_q;
  logic                frame_q;

  display_scan_timer #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .GAP_CYC  (GAP_CYC),
    .IDX_W    (IDX_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .show_nxt (show_nxt),
    .idx_nxt  (idx_nxt),
    .wrap     (wrap)
  );

  // A load coinciding with the wrap goes straight to active so the newest value wins.
  always_comb begin
    active_d   = active_q;
    pending_d  = pending_q;
    pend_vld_d = pend_vld_q;
    if (wrap) begin
      if (bus.load) begin
        active_d = bus.value;
      end else if (pend_vld_q) begin
        active_d = pending_q;
      end
      pend_vld_d = 1'b0;
    end else if (bus.load) begin
      pending_d  = bus.value;
      pend_vld_d = 1'b1;
    end
  end

  always_comb begin
    lz_vec = '0;
    lz_run = bus.blank_lz;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz_run    = lz_run && (active_d[i*NIBBLE_W +: NIBBLE_W] == SEG_DARK);
      lz_vec[i] = lz_run;
    end
  end

  always_comb begin
    seg_d = SEG_DARK;
    sel_d = '0;
    if (show_nxt) begin
      for (int i = 0; i < DIGITS; i++) begin
        if ((idx_nxt == IDX_W'(i)) && !lz_vec[i]) begin
          sel_d[i] = 1'b1;
          seg_d    = active_d[i*NIBBLE_W +: NIBBLE_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q   <= '0;
      pending_q  <= '0;
      pend_vld_q <= 1'b0;
      seg_q      <= SEG_DARK;
      sel_q      <= '0;
      frame_q    <= 1'b0;
    end else begin
      active_q   <= active_d;
      pending_q  <= pending_d;
      pend_vld_q <= pend_vld_d;
      seg_q      <= seg_d;
      sel_q      <= sel_d;
      frame_q    <= wrap;
    end
  end

  assign bus.seg_val   = seg_q;
  assign bus.digit_sel = sel_q;
  assign bus.frame     = frame_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Scoreboard bench for display_scan_driver: frame-position reference model, directed and random stimulus.
module tb_display_scan_driver;
  import display_pkg::*;

  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 4;
  localparam int GAP_CYC   = 1;
  localparam int DIG_PER   = SCAN_DIV + GAP_CYC;
  localparam int FRAME_LEN = DIGITS * DIG_PER;

  logic clk = 1'b0;
  logic rst = 1'b1;

  display_scan_driver_if #(.DIGITS(DIGITS)) bus ();

  display_scan_driver #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .GAP_CYC  (GAP_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]        seg;
    logic [DIGITS-1:0] sel;
    logic              frame;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: cycles since reset release place us in the frame.
  int          k         = 0;
  logic [15:0] m_active  = '0;
  logic [15:0] m_pending = '0;
  bit          m_pv      = 1'b0;

  logic [15:0] cur_v  = '0;
  bit          cur_bz = 1'b0;
  bit          r_rnd, ld_rnd;
  int          nz;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  task automatic step(input bit r, input bit ld, input logic [15:0] v, input bit bz);
    exp_t        e;
    int          q, d, w;
    logic [15:0] sh;
    @(negedge clk);
    rst          = r;
    bus.load     = ld;
    bus.value    = v;
    bus.blank_lz = bz;
    e = '0;
    if (r) begin
      k         = 0;
      m_active  = '0;
      m_pending = '0;
      m_pv      = 1'b0;
    end else begin
      k++;
      q = (k - 1) % FRAME_LEN;
      if (q == 0) begin
        if (ld) m_active = v;
        else if (m_pv) m_active = m_pending;
        m_pv = 1'b0;
      end else if (ld) begin
        m_pending = v;
        m_pv      = 1'b1;
      end
      d       = q / DIG_PER;
      w       = q % DIG_PER;
      e.frame = (q == 0);
      if (w < SCAN_DIV) begin
        sh = m_active >> (4 * d);
        if (!(bz && d >= 1 && sh == 16'h0)) begin
          e.sel = 4'(1 << d);
          e.seg = sh[3:0];
        end
      end
    end
    exp_q.push_back(e);
  endtask

  function automatic int next_q();
    return k % FRAME_LEN;
  endfunction

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, cur_v, cur_bz);
  endtask

  task automatic load_v(input logic [15:0] v);
    cur_v = v;
    step(1'b0, 1'b1, v, cur_bz);
  endtask

  task automatic wait_q(input int target);
    for (int i = 0; i < FRAME_LEN && next_q() != target; i++) idle(1);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("seg_val", 16'(bus.seg_val), 16'(e.seg));
        check("digit_sel", 16'(bus.digit_sel), 16'(e.sel));
        check("frame", 16'(bus.frame), 16'(e.frame));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.value    = '0;
    bus.load     = 1'b0;
    bus.blank_lz = 1'b0;
    repeat (3) step(1'b1, 1'b0, 16'h0, 1'b0);

    // basic scan of 1234 loaded in the first (wrap) cycle
    cur_bz = 1'b0;
    load_v(16'h1234);
    idle(45);

    // leading-zero blanking
    cur_bz = 1'b1;
    wait_q(10);
    load_v(16'h0070);
    idle(45);
    load_v(16'h0000);
    idle(45);

    // mid-frame loads: only the last one reaches the next frame
    cur_bz = 1'b0;
    load_v(16'h1234);
    wait_q(0);
    idle(1);
    wait_q(6);
    load_v(16'hABCD);
    wait_q(11);
    load_v(16'h5678);
    idle(25);

    // load in the wrap cycle overrides pending
    wait_q(3);
    load_v(16'h1111);
    wait_q(0);
    load_v(16'h2222);
    idle(45);

    // reset in the middle of digit 2
    wait_q(12);
    step(1'b1, 1'b0, cur_v, cur_bz);
    idle(30);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r_rnd  = ($urandom_range(0, 399) == 0);
      ld_rnd = ($urandom_range(0, 7) == 0);
      if (ld_rnd) begin
        nz    = $urandom_range(0, 4);
        cur_v = 16'($urandom & ((32'h1 << (4 * nz)) - 32'h1));
      end
      if ($urandom_range(0, 39) == 0) cur_bz = ~cur_bz;
      step(r_rnd, ld_rnd, cur_v, cur_bz);
    end

    repeat (3) @(posedge clk);
    #2;
    check("queue_drain", 16'(exp_q.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
